// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} ser_state_t;

    localparam int MAX_SER_WIDTH = 32;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin, with the borrow out of the bit.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > MAX_SER_WIDTH) begin : g_bad_width
        $error("serial_subtractor: WIDTH must be in 2..%0d", MAX_SER_WIDTH);
    end

    ser_state_t       state_q;
    ser_state_t       state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             bq;
    logic [CNT_W-1:0] cnt;
    logic             d;
    logic             bout;
    logic             accept;
    logic             last;

    full_subtractor u_cell (
        .x   (a_sh[0]),
        .y   (b_sh[0]),
        .bin (bq),
        .d   (d),
        .bout(bout)
    );

    // Handshake: start is a request sampled only in IDLE or DONE; the edge that
    // sees it there captures a/b. done is a one-cycle pulse marking diff/borrow
    // updated. start while busy is dropped, never queued.
    assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last     = (cnt == LAST);
    assign res_next = {d, r_sh};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last)  state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            bq       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            bq   <= 1'b0;
            cnt  <= '0;
        end else if (state_q == S_RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= res_next[WIDTH-1:1];
            bq   <= bout;
            // Counter parks on the last bit so it never exceeds WIDTH-1.
            if (last) begin
                diff_q   <= res_next;
                borrow_q <= bout;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases plus random operand pairs.
module tb_serial_subtractor;

    localparam int WIDTH   = 8;
    localparam int RW      = WIDTH + 1;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    logic [RW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic          done_prev = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .borrow(borrow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    // scoreboard: every done pops one expected {borrow, diff}
    always @(negedge clk) begin
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("result", 32'({borrow, diff}), 32'(exp_q.pop_front()));
                end
                check("done_single_cycle", 32'(done_prev), 32'd0);
            end
            done_prev = done;
        end
    end

    // driver: issue one operation from IDLE/DONE and wait for its done
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        int cyc;
        int busy_n;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        exp_q.push_back(model(op_a, op_b));
        @(negedge clk);
        start  = 1'b0;
        a      = WIDTH'($urandom);
        b      = WIDTH'($urandom);
        cyc    = 1;
        busy_n = 0;
        while (!done && cyc < TIMEOUT) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(WIDTH + 1));
        check("busy_cycles", 32'(busy_n), 32'(WIDTH));
        @(negedge clk);
        check("done_low_after", 32'(done), 32'd0);
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!done && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_done", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int n_done;
        int cyc;
        int last_cyc;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_borrow", 32'(borrow), 32'd0);

        run_op(8'h35, 8'h12);
        run_op(8'h12, 8'h35);
        run_op(8'h00, 8'h01);
        run_op(8'hFF, 8'hFF);

        // start pulsed mid-run must be ignored
        a     = 8'h80;
        b     = 8'h01;
        start = 1'b1;
        exp_q.push_back(model(8'h80, 8'h01));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a     = 8'h00;
        b     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_busy", 32'(busy), 32'd1);
        wait_done();
        repeat (12) @(negedge clk);
        check("start_ignored_idle", 32'(busy), 32'd0);

        // asynchronous reset in the middle of a run
        run_op(8'h00, 8'h01);
        a     = 8'h55;
        b     = 8'h0F;
        start = 1'b1;
        exp_q.push_back(model(8'h55, 8'h0F));
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_diff", 32'(diff), 32'd0);
        check("async_borrow", 32'(borrow), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h0A, 8'h03);

        // start held high: back-to-back results every WIDTH+1 cycles
        a     = 8'h10;
        b     = 8'h20;
        start = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(model(8'h10, 8'h20));
        n_done   = 0;
        cyc      = 0;
        last_cyc = 0;
        while (n_done < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (n_done > 0) check("done_period", 32'(cyc - last_cyc), 32'(WIDTH + 1));
                last_cyc = cyc;
                n_done++;
                if (n_done == 5) start = 1'b0;
            end
        end
        start = 1'b0;
        check("throughput_count", 32'(n_done), 32'd5);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            run_op(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
